// File: rtl/swap_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | swap_pkg : shared types, default sizes and bank reset values.      |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
package swap_pkg;

  localparam int SWAP_W = 6;
  localparam int SWAP_N = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    MOVE  = 2'd2,
    STORE = 2'd3
  } swap_state_e;

  // Callers truncate to the data width, giving (idx+1) mod 2^W.
  function automatic int swap_rst_val(input int idx);
    return idx + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/swap_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | swap_arbiter_if : requester/observer bundle for swap_arbiter.      |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
interface swap_arbiter_if
  import swap_pkg::*;
#(
  parameter int W = SWAP_W,
  parameter int N = SWAP_N
);
  localparam int IDX_W = $clog2(N);

  logic [1:0]       req;
  logic [IDX_W-1:0] a0;
  logic [IDX_W-1:0] b0;
  logic [IDX_W-1:0] a1;
  logic [IDX_W-1:0] b1;
  logic [1:0]       gnt;
  logic             busy;
  logic             done;
  logic [IDX_W-1:0] rd_idx;
  logic [W-1:0]     rd_data;

  modport master (
    output req, a0, b0, a1, b1, rd_idx,
    input  gnt, busy, done, rd_data
  );

  modport slave (
    input  req, a0, b0, a1, b1, rd_idx,
    output gnt, busy, done, rd_data
  );

endinterface
`default_nettype wire

// File: rtl/swap_regbank.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | swap_regbank : N x W register bank plus tmp, one write port.       |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module swap_regbank
  import swap_pkg::*;
#(
  parameter int  W     = SWAP_W,
  parameter int  N     = SWAP_N,
  localparam int IDX_W = $clog2(N)
) (
  input  wire logic             ck,
  input  wire logic             rst,
  input  wire logic             tmp_ld_i,
  input  wire logic             wr_en_i,
  input  wire logic [IDX_W-1:0] wr_idx_i,
  input  wire logic [W-1:0]     wr_data_i,
  input  wire logic [IDX_W-1:0] ra_idx_i,
  input  wire logic [IDX_W-1:0] rb_idx_i,
  input  wire logic [IDX_W-1:0] rd_idx_i,
  output logic      [W-1:0]     ra_data_o,
  output logic      [W-1:0]     tmp_o,
  output logic      [W-1:0]     rd_data_o
);

  logic [W-1:0] r_q [N];
  logic [W-1:0] tmp_q;

  always_ff @(posedge ck) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        r_q[i] <= W'(swap_rst_val(i));
      end
      tmp_q <= '0;
    end else begin
      if (wr_en_i) begin
        r_q[wr_idx_i] <= wr_data_i;
      end
      if (tmp_ld_i) begin
        tmp_q <= r_q[rb_idx_i];
      end
    end
  end

  assign ra_data_o = r_q[ra_idx_i];
  assign tmp_o     = tmp_q;
  assign rd_data_o = r_q[rd_idx_i];

endmodule
`default_nettype wire

// File: rtl/swap_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | swap_arbiter : two-requester register swap sequencer.              |
// | SWAP_ARB_RR_EN selects round-robin, else fixed priority to req 0.  |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module swap_arbiter
  import swap_pkg::*;
#(
  parameter int  W     = SWAP_W,
  parameter int  N     = SWAP_N,
  localparam int IDX_W = $clog2(N)
) (
  input wire logic      ck,
  input wire logic      rst,
  swap_arbiter_if.slave bus
);

  swap_state_e      state_q, state_d;
  logic [IDX_W-1:0] sa_q, sa_d;
  logic [IDX_W-1:0] sb_q, sb_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             accept;
  logic             win;
  logic             tmp_ld;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [W-1:0]     wr_data;
  logic [W-1:0]     ra_data;
  logic [W-1:0]     tmp_data;

  assign accept = (state_q == IDLE) && (bus.req != 2'b00);

`ifdef SWAP_ARB_RR_EN
  // ptr_q holds the last granted requester; a tie goes to the other one.
  logic ptr_q, ptr_d;

  always_comb begin
    win   = (bus.req == 2'b11) ? ~ptr_q : bus.req[1];
    ptr_d = accept ? win : ptr_q;
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      ptr_q <= 1'b1;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  always_comb begin
    win = ~bus.req[0];
  end
`endif

  always_ff @(posedge ck) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      gnt_q   <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    gnt_d   = 2'b00;
    busy_d  = busy_q;
    done_d  = 1'b0;
    tmp_ld  = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = sb_q;
    wr_data = ra_data;
    case (state_q)
      IDLE: begin
        if (accept) begin
          sa_d    = win ? bus.a1 : bus.a0;
          sb_d    = win ? bus.b1 : bus.b0;
          gnt_d   = win ? 2'b10 : 2'b01;
          busy_d  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        tmp_ld  = 1'b1;
        state_d = MOVE;
      end
      MOVE: begin
        wr_en   = 1'b1;
        wr_idx  = sb_q;
        wr_data = ra_data;
        state_d = STORE;
      end
      STORE: begin
        wr_en   = 1'b1;
        wr_idx  = sa_q;
        wr_data = tmp_data;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  swap_regbank #(
    .W (W),
    .N (N)
  ) u_bank (
    .ck        (ck),
    .rst       (rst),
    .tmp_ld_i  (tmp_ld),
    .wr_en_i   (wr_en),
    .wr_idx_i  (wr_idx),
    .wr_data_i (wr_data),
    .ra_idx_i  (sa_q),
    .rb_idx_i  (sb_q),
    .rd_idx_i  (bus.rd_idx),
    .ra_data_o (ra_data),
    .tmp_o     (tmp_data),
    .rd_data_o (bus.rd_data)
  );

  assign bus.gnt  = gnt_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_swap_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_swap_arbiter : per-cycle vector table for swap_arbiter.         |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module tb_swap_arbiter;

  typedef struct {
    bit          rst;
    logic [1:0]  req;
    logic [1:0]  a0, b0, a1, b1;
    logic [1:0]  gnt;
    logic        busy;
    logic        done;
    bit          chk;
    logic [23:0] bank;   // {r3, r2, r1, r0}
  } vec_t;

  logic ck;
  logic rst;
  int   n_chk;
  int   n_fail;
  vec_t tbl[$];

  swap_arbiter_if #(.W(6), .N(4)) bif ();

  swap_arbiter #(.W(6), .N(4)) dut (
    .ck  (ck),
    .rst (rst),
    .bus (bif)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  function automatic logic [23:0] bk(input int r0, input int r1, input int r2, input int r3);
    return {6'(r3), 6'(r2), 6'(r1), 6'(r0)};
  endfunction

  function automatic vec_t mk(input bit r, input logic [1:0] rq,
                              input int a0, input int b0, input int a1, input int b1,
                              input logic [1:0] g, input logic bu, input logic dn,
                              input bit c, input logic [23:0] bnk);
    vec_t v;
    v.rst  = r;
    v.req  = rq;
    v.a0   = 2'(a0);
    v.b0   = 2'(b0);
    v.a1   = 2'(a1);
    v.b1   = 2'(b1);
    v.gnt  = g;
    v.busy = bu;
    v.done = dn;
    v.chk  = c;
    v.bank = bnk;
    return v;
  endfunction

  task automatic check_bit(input string nm, input int row, input logic [1:0] got, input logic [1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL row %0d %s: got %b expected %b", row, nm, got, exp);
    end
  endtask

  task automatic check_bank(input int row, input logic [23:0] exp);
    logic [5:0] e;
    for (int i = 0; i < 4; i++) begin
      bif.rd_idx = 2'(i);
      #1;
      e = exp[i*6 +: 6];
      n_chk++;
      if (bif.rd_data !== e) begin
        n_fail++;
        $display("FAIL row %0d r[%0d]: got %0d expected %0d", row, i, bif.rd_data, e);
      end
    end
  endtask

`ifdef SWAP_ARB_RR_EN
  localparam logic [1:0] G2 = 2'b10;
  localparam int         B2_0 = 2, B2_1 = 1, B2_2 = 4, B2_3 = 3;
`else
  localparam logic [1:0] G2 = 2'b01;
  localparam int         B2_0 = 1, B2_1 = 2, B2_2 = 3, B2_3 = 4;
`endif

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    bif.req = 2'b00; bif.a0 = '0; bif.b0 = '0; bif.a1 = '0; bif.b1 = '0; bif.rd_idx = '0;

    // reset state, then a single swap of r0/r2
    tbl.push_back(mk(1, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 1, bk(1, 2, 3, 4)));
    tbl.push_back(mk(0, 2'b01, 0, 2, 0, 0, 2'b01, 1, 0, 0, '0));
    tbl.push_back(mk(0, 2'b00, 0, 2, 0, 0, 2'b00, 1, 0, 0, '0));
    tbl.push_back(mk(0, 2'b00, 0, 2, 0, 0, 2'b00, 1, 0, 0, '0));
    tbl.push_back(mk(0, 2'b00, 0, 2, 0, 0, 2'b00, 0, 1, 1, bk(3, 2, 1, 4)));
    tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, '0));
    // both requesters held: four back-to-back swaps
    tbl.push_back(mk(1, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 1, bk(1, 2, 3, 4)));
    tbl.push_back(mk(0, 2'b11, 0, 1, 2, 3, 2'b01, 1, 0, 0, '0));
    tbl.push_back(mk(0, 2'b11, 0, 1, 2, 3, 2'b00, 1, 0, 0, '0));
    tbl.push_back(mk(0, 2'b11, 0, 1, 2, 3, 2'b00, 1, 0, 0, '0));
    tbl.push_back(mk(0, 2'b11, 0, 1, 2, 3, 2'b00, 0, 1, 0, '0));
    tbl.push_back(mk(0, 2'b11, 0, 1, 2, 3, G2,    1, 0, 0, '0));
    tbl.push_back(mk(0, 2'b11, 0, 1, 2, 3, 2'b00, 1, 0, 0, '0));
    tbl.push_back(mk(0, 2'b11, 0, 1, 2, 3, 2'b00, 1, 0, 0, '0));
    tbl.push_back(mk(0, 2'b11, 0, 1, 2, 3, 2'b00, 0, 1, 1, bk(B2_0, B2_1, B2_2, B2_3)));
    tbl.push_back(mk(0, 2'b11, 0, 1, 2, 3, 2'b01, 1, 0, 0, '0));
    tbl.push_back(mk(0, 2'b11, 0, 1, 2, 3, 2'b00, 1, 0, 0, '0));
    tbl.push_back(mk(0, 2'b11, 0, 1, 2, 3, 2'b00, 1, 0, 0, '0));
    tbl.push_back(mk(0, 2'b11, 0, 1, 2, 3, 2'b00, 0, 1, 0, '0));
    tbl.push_back(mk(0, 2'b11, 0, 1, 2, 3, G2,    1, 0, 0, '0));
    tbl.push_back(mk(0, 2'b11, 0, 1, 2, 3, 2'b00, 1, 0, 0, '0));
    tbl.push_back(mk(0, 2'b11, 0, 1, 2, 3, 2'b00, 1, 0, 0, '0));
    tbl.push_back(mk(0, 2'b11, 0, 1, 2, 3, 2'b00, 0, 1, 1, bk(1, 2, 3, 4)));
    tbl.push_back(mk(0, 2'b00, 0, 1, 2, 3, 2'b00, 0, 0, 0, '0));
    // a1 == b1: full sequence, contents unchanged
    tbl.push_back(mk(0, 2'b10, 0, 0, 3, 3, 2'b10, 1, 0, 0, '0));
    tbl.push_back(mk(0, 2'b00, 0, 0, 3, 3, 2'b00, 1, 0, 0, '0));
    tbl.push_back(mk(0, 2'b00, 0, 0, 3, 3, 2'b00, 1, 0, 0, '0));
    tbl.push_back(mk(0, 2'b00, 0, 0, 3, 3, 2'b00, 0, 1, 1, bk(1, 2, 3, 4)));
    // indices change after grant: only the latched pair (1,3) swaps
    tbl.push_back(mk(0, 2'b01, 1, 3, 0, 0, 2'b01, 1, 0, 0, '0));
    tbl.push_back(mk(0, 2'b00, 0, 2, 0, 0, 2'b00, 1, 0, 0, '0));
    tbl.push_back(mk(0, 2'b00, 2, 0, 0, 0, 2'b00, 1, 0, 0, '0));
    tbl.push_back(mk(0, 2'b00, 2, 0, 0, 0, 2'b00, 0, 1, 1, bk(1, 4, 3, 2)));
    // reset right after the MOVE edge abandons the swap
    tbl.push_back(mk(0, 2'b01, 0, 3, 0, 0, 2'b01, 1, 0, 0, '0));
    tbl.push_back(mk(0, 2'b00, 0, 3, 0, 0, 2'b00, 1, 0, 0, '0));
    tbl.push_back(mk(0, 2'b00, 0, 3, 0, 0, 2'b00, 1, 0, 1, bk(1, 4, 3, 1)));
    tbl.push_back(mk(1, 2'b00, 0, 3, 0, 0, 2'b00, 0, 0, 1, bk(1, 2, 3, 4)));
    tbl.push_back(mk(0, 2'b00, 0, 3, 0, 0, 2'b00, 0, 0, 0, '0));
    // tie right after reset goes to requester 0 again
    tbl.push_back(mk(0, 2'b11, 0, 1, 2, 3, 2'b01, 1, 0, 0, '0));
    tbl.push_back(mk(0, 2'b00, 0, 1, 2, 3, 2'b00, 1, 0, 0, '0));
    tbl.push_back(mk(0, 2'b00, 0, 1, 2, 3, 2'b00, 1, 0, 0, '0));
    tbl.push_back(mk(0, 2'b00, 0, 1, 2, 3, 2'b00, 0, 1, 1, bk(2, 1, 3, 4)));
    tbl.push_back(mk(0, 2'b00, 0, 1, 2, 3, 2'b00, 0, 0, 0, '0));

    foreach (tbl[k]) begin
      rst     = tbl[k].rst;
      bif.req = tbl[k].req;
      bif.a0  = tbl[k].a0;
      bif.b0  = tbl[k].b0;
      bif.a1  = tbl[k].a1;
      bif.b1  = tbl[k].b1;
      @(posedge ck);
      @(negedge ck);
      check_bit("gnt",  k, bif.gnt, tbl[k].gnt);
      check_bit("busy", k, {1'b0, bif.busy}, {1'b0, tbl[k].busy});
      check_bit("done", k, {1'b0, bif.done}, {1'b0, tbl[k].done});
      if (tbl[k].chk) begin
        check_bank(k, tbl[k].bank);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/swap_arbiter.md
# swap_arbiter

Sequencing controller for a small register bank that performs three-step register swaps through a temporary register, shared between two requesters. Each requester presents a pair of register indices; the controller arbitrates, latches the pair, and runs the temp-load / move / store sequence. It sits between the requesting FSMs and the swap datapath, and exposes a read port for observation.

## Interface
- `W`, 6: register data width.
- `N`, 4: number of registers in the bank. Must be a power of two; `IDX_W = log2(N)`.
- `ck`  in  1  clock, rising edge.
- `rst`  in  1  reset. Synchronous and active-high.
- `req`  in  2  per-requester request level; bit i belongs to requester i.
- `a0`, `b0`  in  IDX_W each  register index pair for requester 0.
- `a1`, `b1`  in  IDX_W each  register index pair for requester 1.
- `gnt`  out  2  one-hot grant pulse, registered.
- `busy`  out  1  a swap is in progress, registered.
- `done`  out  1  one-cycle completion pulse, registered.
- `rd_idx`  in  IDX_W  observation read index.
- `rd_data`  out  W  `r[rd_idx]`, combinational.

## Operation
- The bank holds registers r[0..N-1] and one temporary register `tmp`, all W bits wide.
- FSM has four states: IDLE=0, LOAD=1, MOVE=2, STORE=3.
- **IDLE**
  - If `req` != 0: arbitrate, latch the winner's (a, b) into `sa`/`sb`, set `gnt[winner]`=1, set `busy`=1, then go to LOAD.
  - Otherwise stay in IDLE.
- **LOAD**: `tmp <= r[sb]`; go to MOVE.
- **MOVE**: `r[sb] <= r[sa]`; go to STORE.
- **STORE**: `r[sa] <= tmp`; set `done`=1 for the next cycle, clear `busy`, go to IDLE.
- `req` is ignored outside IDLE. Requester index inputs are sampled only at grant; later changes to them do not affect the swap in flight.
- **Arbitration**: round-robin with a last-grant pointer (see Configuration). On a tie, the requester not granted last wins. If only one requester is active, it wins regardless of the pointer. The pointer updates on every grant.
- **a == b**: the full sequence still runs; register contents are unchanged; `done` still pulses.
- A held `req` level is a new request. A requester that keeps `req` high after its grant gets another swap at the next IDLE.
- **Reset values**:
  - state=IDLE, `gnt`=0, `busy`=0, `done`=0.
  - r[i] = (i+1) mod 2^W, `tmp`=0, `sa`=`sb`=0.
  - Pointer = 1, so requester 0 wins the first tie.
- **Reset mid-swap**: the sequence is abandoned, every register takes its reset value, and no `done` pulse is produced.
- `rst` has priority over all other events in the same cycle.

## Timing
- Accept at edge k. In cycle k+1: `gnt`=1, `busy`=1.
- Edge k+1: `tmp` is loaded. Edge k+2: r[b] is written. Edge k+3: r[a] is written.
- In cycle k+4: `done`=1, `busy`=0. The earliest next accept is edge k+4.
- Throughput: one swap per 4 cycles under back-to-back requests. `done` and the next `gnt` never coincide; the next `gnt` appears in cycle k+5.
- `rd_data` shows intermediate bank contents during a swap: after edge k+2, r[a] and r[b] are equal.

## Configuration
- `SWAP_ARB_RR_EN` defined: round-robin arbitration as described above.
- `SWAP_ARB_RR_EN` undefined: fixed priority, requester 0 always wins. The pointer register is not built. Requester 1 can starve.

## Structure
- Package `swap_pkg` holds:
  - the state enum: IDLE, LOAD, MOVE, STORE;
  - default constants `SWAP_W`=6 and `SWAP_N`=4;
  - the reset-value function r[i] = i+1.
- Sub-module `swap_regbank`: the N×W registers plus `tmp`, with one write port, a `tmp` load, two internal async read ports (indexed by `sa`/`sb`) and the observation port. It also handles the synchronous reset values.
- `swap_arbiter` contains the FSM, the arbiter and the `sa`/`sb` latches.

## Test plan
- Reset, then `req`=01 with `a0`=0, `b0`=2 for one cycle → `gnt`=01 in cycle 1; `done` in cycle 4; r[0]=3, r[2]=1, r[1]=2, r[3]=4.
- `req`=11 held, pairs (0,1) and (2,3) → grants in order 01, 10, 01, 10 with 4-cycle spacing; first two swaps give r = {2,1,4,3}. With the macro undefined: only 01 is ever granted.
- `a1`=`b1`=3 → `busy` for 3 cycles, `done` pulses, r[3]=4 unchanged.
- Change `a0` and `b0` during LOAD/MOVE → only the latched pair is swapped.
- Assert `rst` in the cycle after the MOVE edge → next cycle: bank = {1,2,3,4}, `busy`=0, no `done` pulse.
